worker_cpu_debug_vjtag_master: RTL and testbench

- Drives the virtual-JTAG side of the CPU debug slave from a system-clock command interface.
- Accepts one debug transaction per command: a 2-bit instruction and a 38-bit data register. It sequences UIR → CDR → SDR → UDR on a generated TCK, shifts TDI and captures TDO, then returns the captured word.
- Used as the on-chip or simulation debug host for the worker CPU; it replaces the physical JTAG hub.

---
 rtl/worker_cpu_debug_pkg.sv | 31 +++
 rtl/worker_cpu_debug_tck_gen.sv | 46 ++++
 rtl/worker_cpu_debug_vjtag_master.sv | 158 +++++++++++++++
 tb/tb_worker_cpu_debug_vjtag_master.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/worker_cpu_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : worker_cpu_debug_pkg
// Description : Shared types and constants for the worker CPU virtual-JTAG
//               debug master: sequencer state encoding, instruction codes
//               and the default data-register length.
// Revision    : 1.0 - initial release
// ============================================================================
package worker_cpu_debug_pkg;

    // Sequencer states of the debug master
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UIR  = 3'd1,
        CDR  = 3'd2,
        SDR  = 3'd3,
        UDR  = 3'd4,
        RTI  = 3'd5,
        RESP = 3'd6
    } state_t;

    // Instruction codes understood by the CPU debug slave
    localparam logic [1:0] IR_OCIMEM = 2'd0;
    localparam logic [1:0] IR_TRACE  = 2'd1;
    localparam logic [1:0] IR_BREAK  = 2'd2;
    localparam logic [1:0] IR_ENABLE = 2'd3;

    localparam int DR_WIDTH_DEFAULT = 38;

endpackage
`default_nettype wire

// File: rtl/worker_cpu_debug_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : worker_cpu_debug_tck_gen
// Description : Test-clock divider. Produces tck plus single-cycle rise and
//               fall tick strobes that flag the clk edge on which tck will
//               rise or fall. Counting only happens while run is high; the
//               counter parks at 0 after each completed period.
// Revision    : 1.0 - initial release
// ============================================================================
module worker_cpu_debug_tck_gen #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic restart,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int             CW      = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0]  HALF    = CW'(TCK_DIV / 2);
    localparam logic [CW-1:0]  HALF_M1 = CW'(TCK_DIV / 2 - 1);
    localparam logic [CW-1:0]  LAST    = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Divider counter: restart forces phase 0, otherwise wrap at TCK_DIV-1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // tck is high for the second half of each period, so it drops with reset
    assign tck  = (cnt_q >= HALF);
    assign rise = run && (cnt_q == HALF_M1);
    assign fall = run && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/worker_cpu_debug_vjtag_master.sv
`default_nettype none
// ============================================================================
// Module      : worker_cpu_debug_vjtag_master
// Description : Virtual-JTAG debug host. One command = one IR/DR transaction
//               sequenced UIR -> CDR -> SDR -> UDR on a divided tck; the word
//               captured from tdo during SDR is returned on the response port.
//               Optional build macro WORKER_CPU_DEBUG_VJTAG_RTI_EN inserts a
//               run-test-idle phase of RTI_CYCLES tck periods after UDR.
// Revision    : 1.0 - initial release
// ============================================================================
import worker_cpu_debug_pkg::*;

module worker_cpu_debug_vjtag_master #(
    parameter int IR_WIDTH   = 2,
    parameter int DR_WIDTH   = DR_WIDTH_DEFAULT,
    parameter int TCK_DIV    = 4,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int            BW       = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    state_t                state_q;
    state_t                state_d;
    logic [IR_WIDTH-1:0]   ir_q;
    logic [DR_WIDTH-1:0]   sh_q;
    logic [DR_WIDTH-1:0]   cap_q;
    logic [BW-1:0]         bit_q;
    logic                  accept;
    logic                  run;
    logic                  rise;
    logic                  fall;

    assign accept = cmd_valid && (state_q == IDLE);
    assign run    = (state_q != IDLE) && (state_q != RESP);

    worker_cpu_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .restart (accept),
        .tck     (tck),
        .rise    (rise),
        .fall    (fall)
    );

`ifdef WORKER_CPU_DEBUG_VJTAG_RTI_EN
    localparam int            RW       = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

    logic [RW-1:0] rti_q;

    // Counts completed tck periods spent in run-test-idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rti_q <= '0;
        end else if (state_q != RTI) begin
            rti_q <= '0;
        end else if (fall) begin
            rti_q <= rti_q + RW'(1);
        end
    end

    assign jtag_state_rti = (state_q == RTI);
`else
    logic unused_rti_cfg;
    assign unused_rti_cfg = (RTI_CYCLES != 0);
    assign jtag_state_rti = 1'b0;
`endif

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every JTAG-side transition happens on a tck fall tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_valid) state_d = UIR;
            UIR:  if (fall) state_d = CDR;
            CDR:  if (fall) state_d = SDR;
            SDR:  if (fall && (bit_q == BIT_LAST)) state_d = UDR;
`ifdef WORKER_CPU_DEBUG_VJTAG_RTI_EN
            UDR:  if (fall) state_d = RTI;
            RTI:  if (fall && (rti_q == RTI_LAST)) state_d = RESP;
`else
            UDR:  if (fall) state_d = RESP;
            RTI:  state_d = IDLE;
`endif
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch command on accept, shift out on fall, capture on rise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_q  <= '0;
            sh_q  <= '0;
            cap_q <= '0;
            bit_q <= '0;
        end else begin
            if (accept) begin
                ir_q  <= cmd_ir;
                sh_q  <= cmd_data;
                bit_q <= '0;
            end else if (state_q == SDR) begin
                if (rise) begin
                    cap_q <= {tdo, cap_q[DR_WIDTH-1:1]};
                end
                if (fall) begin
                    sh_q <= {1'b0, sh_q[DR_WIDTH-1:1]};
                    if (bit_q != BIT_LAST) begin
                        bit_q <= bit_q + BW'(1);
                    end
                end
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = cap_q;
    assign tdi       = sh_q[0];
    assign ir_in     = ir_q;
    assign vs_uir    = (state_q == UIR);
    assign vs_cdr    = (state_q == CDR);
    assign vs_sdr    = (state_q == SDR);
    assign vs_udr    = (state_q == UDR);

endmodule
`default_nettype wire

// File: tb/tb_worker_cpu_debug_vjtag_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_worker_cpu_debug_vjtag_master
// Description : Directed self-checking bench for the virtual-JTAG debug
//               master (loopback, constant tdo, strobe timing, backpressure,
//               mid-transaction reset, optional run-test-idle phase).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_worker_cpu_debug_vjtag_master;

`ifdef WORKER_CPU_DEBUG_VJTAG_RTI_EN
    localparam int EXP_RTI = 8;
`else
    localparam int EXP_RTI = 0;
`endif
    localparam int EXP_LAT = 164 + EXP_RTI;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [37:0] rsp_data;
    logic        tck;
    logic        tdi;
    logic        tdo;
    logic [1:0]  ir_in;
    logic        vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    logic        loop_mode;
    logic        tdo_fixed;
    assign tdo = loop_mode ? tdi : tdo_fixed;

    int checks = 0;
    int errors = 0;

    // statistics gathered by run_txn
    int          lat;
    logic [37:0] got;
    int n_uir, n_cdr, n_sdr, n_udr, n_rti, sdr_rises, overlap, sdr_tdi_ones, ir_bad;

    worker_cpu_debug_vjtag_master #(
        .IR_WIDTH   (2),
        .DR_WIDTH   (38),
        .TCK_DIV    (4),
        .RTI_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .tck            (tck),
        .tdi            (tdi),
        .tdo            (tdo),
        .ir_in          (ir_in),
        .vs_uir         (vs_uir),
        .vs_cdr         (vs_cdr),
        .vs_sdr         (vs_sdr),
        .vs_udr         (vs_udr),
        .jtag_state_rti (jtag_state_rti)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and monitor it until rsp_valid; optionally acknowledge
    task automatic run_txn(input logic [1:0] ir, input logic [37:0] data, input bit ack);
        logic prev_tck;
        int   ones;
        prev_tck = 1'b0;
        lat = -1; got = '0;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
        sdr_rises = 0; overlap = 0; sdr_tdi_ones = 0; ir_bad = 0;
        cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 0; c <= 400; c++) begin
            if (c > 0) step();
            if (rsp_valid) begin
                lat = c;
                got = rsp_data;
                break;
            end
            if (ir_in !== ir) ir_bad++;
            ones = int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr) + int'(jtag_state_rti);
            if (ones > 1) overlap++;
            if (vs_uir) n_uir++;
            if (vs_cdr) n_cdr++;
            if (vs_sdr) n_sdr++;
            if (vs_udr) n_udr++;
            if (jtag_state_rti) n_rti++;
            if (vs_sdr && tdi) sdr_tdi_ones++;
            if (vs_sdr && !prev_tck && tck) sdr_rises++;
            prev_tck = tck;
        end
        if (ack && lat >= 0) begin
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cmd_ready, rsp_valid, tck, tdi} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000", {cmd_ready, rsp_valid, tck, tdi});
        end
        checks++;
        if (rsp_data !== 38'h0 || ir_in !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: got rsp_data=%h ir_in=%b expected 0", rsp_data, ir_in);
        end
        checks++;
        if ({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti} !== 5'b0) begin
            errors++;
            $display("FAIL reset_vs: got %b expected 00000",
                     {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti});
        end
    endtask

    task automatic test_loopback();
        loop_mode = 1'b1;
        run_txn(2'b10, 38'h2A_5555_AAAA, 1'b1);
        checks++;
        if (got !== 38'h2A_5555_AAAA) begin
            errors++;
            $display("FAIL loopback_data: got %h expected %h", got, 38'h2A_5555_AAAA);
        end
        checks++;
        if (lat != EXP_LAT) begin
            errors++;
            $display("FAIL loopback_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        checks++;
        if (ir_bad != 0) begin
            errors++;
            $display("FAIL loopback_ir_in: got %0d bad cycles expected 0", ir_bad);
        end
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL loopback_idle: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
        end
        run_txn(2'b01, 38'h15_0F0F_1234, 1'b1);
        checks++;
        if (got !== 38'h15_0F0F_1234) begin
            errors++;
            $display("FAIL loopback_data2: got %h expected %h", got, 38'h15_0F0F_1234);
        end
    endtask

    task automatic test_tdo_ones();
        loop_mode = 1'b0;
        tdo_fixed = 1'b1;
        run_txn(2'b00, 38'h0, 1'b1);
        checks++;
        if (got !== 38'h3F_FFFF_FFFF) begin
            errors++;
            $display("FAIL ones_data: got %h expected %h", got, 38'h3F_FFFF_FFFF);
        end
        checks++;
        if (sdr_tdi_ones != 0) begin
            errors++;
            $display("FAIL ones_tdi: got %0d high cycles expected 0", sdr_tdi_ones);
        end
        checks++;
        if (sdr_rises != 38) begin
            errors++;
            $display("FAIL ones_rises: got %0d expected 38", sdr_rises);
        end
        tdo_fixed = 1'b0;
    endtask

    task automatic test_strobes();
        loop_mode = 1'b1;
        run_txn(2'b11, 38'h00_0000_0001, 1'b1);
        checks++;
        if (n_uir != 4 || n_cdr != 4) begin
            errors++;
            $display("FAIL strobe_uir_cdr: got %0d %0d expected 4 4", n_uir, n_cdr);
        end
        checks++;
        if (n_sdr != 152 || n_udr != 4) begin
            errors++;
            $display("FAIL strobe_sdr_udr: got %0d %0d expected 152 4", n_sdr, n_udr);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d expected 0", overlap);
        end
        checks++;
        if (n_rti != EXP_RTI) begin
            errors++;
            $display("FAIL strobe_rti: got %0d expected %0d", n_rti, EXP_RTI);
        end
        checks++;
        if (got !== 38'h00_0000_0001) begin
            errors++;
            $display("FAIL strobe_data: got %h expected %h", got, 38'h00_0000_0001);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        int lat2;
        loop_mode = 1'b1;
        run_txn(2'b10, 38'h12_3456_789A, 1'b0);
        checks++;
        if (lat != EXP_LAT) begin
            errors++;
            $display("FAIL bp_first_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        // second command pending while the response is held off
        cmd_ir = 2'b01; cmd_data = 38'h0B_CDEF_0123; cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_data !== 38'h12_3456_789A || cmd_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if ({cmd_ready, rsp_valid, vs_uir} !== 3'b100) begin
            errors++;
            $display("FAIL bp_after_handshake: got %b expected 100", {cmd_ready, rsp_valid, vs_uir});
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, vs_uir, ir_in} !== 4'b0101) begin
            errors++;
            $display("FAIL bp_second_accept: got %b expected 0101", {cmd_ready, vs_uir, ir_in});
        end
        lat2 = -1;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (rsp_valid) begin
                lat2 = c;
                break;
            end
        end
        checks++;
        if (lat2 != EXP_LAT || rsp_data !== 38'h0B_CDEF_0123) begin
            errors++;
            $display("FAIL bp_second_rsp: got lat=%0d data=%h expected %0d %h",
                     lat2, rsp_data, EXP_LAT, 38'h0B_CDEF_0123);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        loop_mode = 1'b1;
        cmd_ir = 2'b11; cmd_data = 38'h3F_0000_FFFF; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        // SDR bit 17 spans samples 76..79 after accept; 78 is its tck-high half
        for (int i = 0; i < 78; i++) step();
        checks++;
        if ({vs_sdr, tck} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre: got vs_sdr,tck=%b expected 11", {vs_sdr, tck});
        end
        reset_n = 1'b0;
        step();
        checks++;
        if ({tck, vs_sdr, cmd_ready, rsp_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL mid_reset: got %b expected 0010", {tck, vs_sdr, cmd_ready, rsp_valid});
        end
        checks++;
        if (rsp_data !== 38'h0 || ir_in !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_data: got %h %b expected 0 00", rsp_data, ir_in);
        end
        reset_n = 1'b1;
        step();
        run_txn(2'b10, 38'h2A_5555_AAAA, 1'b1);
        checks++;
        if (got !== 38'h2A_5555_AAAA || lat != EXP_LAT) begin
            errors++;
            $display("FAIL mid_recover: got %h lat=%0d expected %h %0d",
                     got, lat, 38'h2A_5555_AAAA, EXP_LAT);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_ir    = 2'b00;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        loop_mode = 1'b1;
        tdo_fixed = 1'b0;
        repeat (3) step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_loopback();
        test_tdo_ones();
        test_strobes();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
